// File: rtl/shift_pkg.sv
// Shared mode codes and FSM state encoding for the iterative shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_ROTL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-cycle shifter by 0..STEP bits in SLL/SRL/SRA/ROTL mode.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(STEP + 1)
) (
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [2*WIDTH-1:0] rot_wide;

    always_comb begin
        // Rotate: shift the doubled word, the upper half holds the wrapped bits.
        rot_wide = {din, din} << amt;
        dout     = din;
        case (mode)
            SH_SLL:  dout = din << amt;
            SH_SRL:  dout = din >> amt;
            SH_SRA:  dout = $unsigned($signed(din) >>> amt);
            SH_ROTL: dout = rot_wide[2*WIDTH-1:WIDTH];
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Iterative multi-mode shifter: STEP bits per cycle, start/ready/done handshake.
// Latency: done in the cycle after edge k = ceil(shamt/STEP) past the accept edge.
// Backpressure: start is only taken while ready; start during busy is dropped.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int                 AMT_W  = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] STEP_R = SHAMT_W'(STEP);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] remaining;
    logic [SHAMT_W-1:0] step_sz;
    logic [SHAMT_W-1:0] rem_next;
    logic [AMT_W-1:0]   step_amt;
    logic [1:0]         mode_q;

    assign step_sz  = (remaining > STEP_R) ? STEP_R : remaining;
    assign step_amt = AMT_W'(step_sz);
    assign rem_next = remaining - step_sz;
    assign result   = work;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .mode (mode_q),
        .amt  (step_amt),
        .din  (work),
        .dout (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            remaining <= '0;
            mode_q    <= SH_SLL;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        work      <= din;
                        remaining <= shamt;
                        mode_q    <= mode;
                        if (shamt != '0) begin
                            state <= ST_SHIFT;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            // Zero shift completes straight away with the operand.
                            state <= ST_DONE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work      <= step_out;
                    remaining <= rem_next;
                    if (rem_next == '0) begin
                        state <= ST_DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed-vector bench for seq_shifter with a queue-based scoreboard and done-driven monitor.
module tb_seq_shifter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        int          busy_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_cnt = 0;

    seq_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .shamt  (shamt),
        .din    (din),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse pops one expectation and checks value, timing and busy length.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
                end
                busy_cnt = 0;
            end
        end
    end

    // Call at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [1:0] m, input int sh, input logic [31:0] d,
                         input logic [31:0] r);
        int n;
        int k;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            return;
        end
        k     = (sh + 3) / 4;
        start = 1'b1;
        mode  = m;
        shamt = 5'(sh);
        din   = d;
        exp_q.push_back('{r, cyc + 1 + k, k});
        @(negedge clk);
        start = 1'b0;
        din   = 32'hDEAD_BEEF;
        shamt = 5'd17;
        mode  = SH_ROTL;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = SH_SLL;
        shamt = '0;
        din   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",  32'(ready), 32'd1);
        chk("rst_busy",   32'(busy),  32'd0);
        chk("rst_done",   32'(done),  32'd0);
        chk("rst_result", result,     32'h0000_0000);

        issue(SH_SLL, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFC);    drain();
        issue(SH_SLL, 2, 32'hFF01_F001, 32'hFC07_C004);    drain();
        issue(SH_SRA, 31, 32'h8000_0000, 32'hFFFF_FFFF);   drain();
        issue(SH_SRL, 31, 32'h8000_0000, 32'h0000_0001);   drain();
        issue(SH_ROTL, 4, 32'h8000_0001, 32'h0000_0018);   drain();
        issue(SH_ROTL, 5, 32'h8000_0001, 32'h0000_0030);   drain();
        issue(SH_SRA, 6, 32'hF000_0000, 32'hFFC0_0000);    drain();
        issue(SH_SRA, 0, 32'h9ABC_DEF0, 32'h9ABC_DEF0);    drain();
        issue(SH_ROTL, 0, 32'h1234_5678, 32'h1234_5678);   drain();

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue(SH_SLL, 3, 32'h0004_0000, 32'h0020_0000);
        issue(SH_SRL, 8, 32'h000F_000B, 32'h0000_0F00);
        start = 1'b1;
        mode  = SH_SLL;
        shamt = 5'd1;
        din   = 32'hFFFF_FFFF;
        chk("busy_at_ignored_start", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        chk("result_held", result, 32'h0000_0F00);

        // Reset in the middle of a long SRA must abort without a done pulse.
        issue(SH_SRA, 20, 32'h8000_0000, 32'hFFFF_F800);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",   32'(busy),  32'd0);
        chk("abort_done",   32'(done),  32'd0);
        chk("abort_ready",  32'(ready), 32'd1);
        chk("abort_result", result,     32'h0000_0000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(SH_SLL, 1, 32'h0000_0001, 32'h0000_0002);    drain();

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
